// File: rtl/calc_pkg.sv
// Shared calculator definitions: ALU opcodes, datapath widths, formatter FSM encoding.
package calc_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;

  localparam int RES_W    = 21;
  localparam int REM_W    = 11;
  localparam int RES_DIG  = 6;
  localparam int REM_DIG  = 3;
  // One spare digit per accumulator so out-of-range values are detectable.
  localparam int QACC_DIG = RES_DIG + 1;
  localparam int RACC_DIG = REM_DIG + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV_Q = 2'd1,
    ST_CONV_R = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble step: add 3 to every BCD digit >= 5, then shift left taking i_bit.
// Purely combinational.
module bcd_dabble_step #(
  parameter int N_DIG = 4
) (
  input  logic [4*N_DIG-1:0] i_bcd,
  input  logic               i_bit,
  output logic [4*N_DIG-1:0] o_bcd
);

  logic [4*N_DIG-1:0] w_adj;
  logic               w_unused_msb;

  always_comb begin
    w_adj = i_bcd;
    for (int d = 0; d < N_DIG; d++) begin
      if (i_bcd[4*d +: 4] >= 4'd5) begin
        w_adj[4*d +: 4] = i_bcd[4*d +: 4] + 4'd3;
      end
    end
  end

  // Accumulators are sized so the top digit never exceeds 7; its MSB is always 0.
  assign w_unused_msb = w_adj[4*N_DIG-1];
  assign o_bcd        = {w_adj[4*N_DIG-2:0], i_bit};

endmodule

// File: rtl/result_bcd_formatter.sv
// Serial BCD converter for the ALU result and remainder: sign + digits for the display mux.
// 21 cycles per conversion (32 with remainder); starts arriving while busy are dropped.
module result_bcd_formatter
  import calc_pkg::*;
(
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic                 i_start,
  input  logic [RES_W-1:0]     i_result,
  input  logic                 i_remain,
  input  logic [RES_W-1:0]     i_remainder,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_neg,
  output logic [4*RES_DIG-1:0] o_digits,
  output logic [4*REM_DIG-1:0] o_rem_digits,
  output logic                 o_rem_valid,
  output logic                 o_overflow
);

  state_t                r_state, w_state_nxt;
  logic [4:0]            r_cnt;
  logic [RES_W-1:0]      r_mag;
  logic [REM_W-1:0]      r_rem;
  logic                  r_sign, r_remain;
  logic [4*QACC_DIG-1:0] r_qacc, w_qacc_nxt, w_fin_q;
  logic [4*RACC_DIG-1:0] r_racc, w_racc_nxt, w_fin_r;
  logic                  w_q_last, w_r_last, w_load_out, w_ovf;
  logic                  r_neg, r_rem_valid, r_overflow;
  logic [4*RES_DIG-1:0]  r_digits;
  logic [4*REM_DIG-1:0]  r_rem_digits;
  logic                  w_unused_rem;

  assign w_unused_rem = ^i_remainder[RES_W-1:REM_W];

  bcd_dabble_step #(.N_DIG(QACC_DIG)) u_step_q (
    .i_bcd (r_qacc),
    .i_bit (r_mag[RES_W-1]),
    .o_bcd (w_qacc_nxt)
  );

  bcd_dabble_step #(.N_DIG(RACC_DIG)) u_step_r (
    .i_bcd (r_racc),
    .i_bit (r_rem[REM_W-1]),
    .o_bcd (w_racc_nxt)
  );

  assign w_q_last = (r_cnt == 5'(RES_W - 1));
  assign w_r_last = (r_cnt == 5'(REM_W - 1));

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (i_start) w_state_nxt = ST_CONV_Q;
      ST_CONV_Q: if (w_q_last) w_state_nxt = r_remain ? ST_CONV_R : ST_DONE;
      ST_CONV_R: if (w_r_last) w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy = 1'b0;
    o_done = 1'b0;
    case (r_state)
      ST_CONV_Q, ST_CONV_R: o_busy = 1'b1;
      ST_DONE:              o_done = 1'b1;
      default:              o_busy = 1'b0;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_cnt    <= '0;
      r_mag    <= '0;
      r_rem    <= '0;
      r_sign   <= 1'b0;
      r_remain <= 1'b0;
      r_qacc   <= '0;
      r_racc   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (i_start) begin
          r_sign   <= i_result[RES_W-1];
          r_mag    <= i_result[RES_W-1] ? (~i_result + 1'b1) : i_result;
          r_rem    <= i_remainder[REM_W-1:0];
          r_remain <= i_remain;
          r_qacc   <= '0;
          r_racc   <= '0;
          r_cnt    <= '0;
        end
        ST_CONV_Q: begin
          r_qacc <= w_qacc_nxt;
          r_mag  <= r_mag << 1;
          r_cnt  <= w_q_last ? 5'd0 : r_cnt + 5'd1;
        end
        ST_CONV_R: begin
          r_racc <= w_racc_nxt;
          r_rem  <= r_rem << 1;
          r_cnt  <= r_cnt + 5'd1;
        end
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Outputs load on the final shift edge, so take the accumulator value that edge produces.
  assign w_fin_q    = (r_state == ST_CONV_Q) ? w_qacc_nxt : r_qacc;
  assign w_fin_r    = (r_state == ST_CONV_R) ? w_racc_nxt : r_racc;
  assign w_load_out = ((r_state == ST_CONV_Q) && w_q_last && !r_remain) ||
                      ((r_state == ST_CONV_R) && w_r_last);
  assign w_ovf      = (w_fin_q[4*QACC_DIG-1 -: 4] != 4'd0) ||
                      (w_fin_r[4*RACC_DIG-1 -: 4] != 4'd0);

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_neg        <= 1'b0;
      r_digits     <= '0;
      r_rem_digits <= '0;
      r_rem_valid  <= 1'b0;
      r_overflow   <= 1'b0;
    end else if (w_load_out) begin
      r_neg        <= r_sign && (w_fin_q != '0);
      r_digits     <= w_ovf ? '0 : w_fin_q[4*RES_DIG-1:0];
      r_rem_digits <= w_ovf ? '0 : w_fin_r[4*REM_DIG-1:0];
      r_rem_valid  <= r_remain;
      r_overflow   <= w_ovf;
    end
  end

  assign o_neg        = r_neg;
  assign o_digits     = r_digits;
  assign o_rem_digits = r_rem_digits;
  assign o_rem_valid  = r_rem_valid;
  assign o_overflow   = r_overflow;

endmodule
